// File: rtl/req_grant_arbiter_pkg.sv
// Shared types and defaults for the round-robin burst arbiter.
// Imported by the pick, monitor and top-level modules.
package req_grant_arbiter_pkg;

  localparam int N_REQ_DEF  = 3;
  localparam int BEAT_W_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/req_grant_arbiter_assert.sv
// Companion monitor for the shared port: grant exclusivity and
// no output beat while the arbiter is idle.
module req_grant_arbiter_assert #(
  parameter int N_REQ = 3
) (
  input logic             clock,
  input logic             reset_n,
  input logic [N_REQ-1:0] gnt,
  input logic             out_valid,
  input logic             busy
);

  a_gnt_onehot0: assert property (
    @(posedge clock) disable iff (!reset_n) $onehot0(gnt)
  ) else $fatal(1, "gnt is not at-most-one-hot");

  a_idle_quiet: assert property (
    @(posedge clock) disable iff (!reset_n) out_valid |-> busy
  ) else $fatal(1, "out_valid asserted while idle");

endmodule

// File: rtl/req_grant_arbiter_rr_pick.sv
// Round-robin pick: rotate requests so the slot after last_win
// comes first, priority-encode, then map back to a requester index.
module rr_pick
  import req_grant_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int SEL_W = sel_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last_win,
  output logic [SEL_W-1:0] win,
  output logic             any
);

  logic [N_REQ-1:0] rot;
  int start;
  int off;
  int idx;

  always_comb begin
    start = (int'(last_win) + 1) % N_REQ;
    rot   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (j == (start + i) % N_REQ) rot[i] = req[j];
      end
    end
    off = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = i;
    end
    idx = (start + off) % N_REQ;
    win = SEL_W'(idx);
    any = |req;
  end

endmodule

// File: rtl/req_grant_arbiter.sv
// Round-robin arbiter holding a registered one-hot grant for a
// whole burst and steering the winner's valid to the shared port.
module req_grant_arbiter
  import req_grant_arbiter_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int BEAT_W = BEAT_W_DEF,
  parameter int SEL_W  = sel_w(N_REQ)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*BEAT_W-1:0] req_beats,
  input  logic                    out_ready,
  output logic [N_REQ-1:0]        gnt,
  output logic                    out_valid,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_last,
  output logic                    busy
);

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  gnt_d;
  logic [SEL_W-1:0]  sel_d;
  logic [SEL_W-1:0]  last_q, last_d;
  logic [SEL_W-1:0]  win;
  logic [BEAT_W-1:0] cnt_q, cnt_d;
  logic [BEAT_W-1:0] beats [N_REQ];
  logic              any;
  logic              accept;

  for (genvar i = 0; i < N_REQ; i++) begin : g_beats
    assign beats[i] = req_beats[i*BEAT_W +: BEAT_W];
  end

  rr_pick #(
    .N_REQ(N_REQ),
    .SEL_W(SEL_W)
  ) u_pick (
    .req     (req_valid),
    .last_win(last_q),
    .win     (win),
    .any     (any)
  );

  assign busy      = (state_q == GRANT);
  assign out_valid = busy & req_valid[out_sel];
  assign out_last  = busy & (cnt_q == '0);
  assign accept    = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt;
    sel_d   = out_sel;
    cnt_d   = cnt_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          state_d = GRANT;
          gnt_d   = N_REQ'(1) << win;
          sel_d   = win;
          cnt_d   = beats[win];
        end
      end
      GRANT: begin
        // a dropped req_valid stalls here with the count frozen
        if (accept) begin
          if (out_last) begin
            state_d = IDLE;
            gnt_d   = '0;
            sel_d   = '0;
            last_d  = out_sel;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      gnt     <= '0;
      out_sel <= '0;
      cnt_q   <= '0;
      last_q  <= SEL_W'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      out_sel <= sel_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  req_grant_arbiter_assert #(
    .N_REQ(N_REQ)
  ) u_assert (
    .clock    (clock),
    .reset_n  (reset_n),
    .gnt      (gnt),
    .out_valid(out_valid),
    .busy     (busy)
  );

endmodule

// File: tb/tb_req_grant_arbiter.sv
// Scoreboard bench: a burst-level reference model queues expected
// grants; a negedge monitor pops and checks what the DUT presents.
module tb_req_grant_arbiter;
  import req_grant_arbiter_pkg::*;

  localparam int N  = 5;
  localparam int BW = 4;
  localparam int SW = 3;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N*BW-1:0] req_beats;
  logic            out_ready;
  logic [N-1:0]    gnt;
  logic            out_valid;
  logic [SW-1:0]   out_sel;
  logic            out_last;
  logic            busy;

  req_grant_arbiter #(.N_REQ(N), .BEAT_W(BW)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .req_valid(req_valid),
    .req_beats(req_beats),
    .out_ready(out_ready),
    .gnt      (gnt),
    .out_valid(out_valid),
    .out_sel  (out_sel),
    .out_last (out_last),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  typedef struct { int who; int len; } burst_t;

  burst_t exp_q[$];
  int     glog[$];
  int     gcyc[$];
  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;

  // reference model: burst owner, beats remaining, last winner
  bit m_busy = 0;
  int m_owner = 0;
  int m_rem = 0;
  int m_last = N - 1;
  int done_who = -1;

  // requester agents
  bit pend[N];
  bit rearm[N];
  int bts[N];
  int drop[N];
  bit rand_mode = 0;

  task automatic check(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               name, act, want, cyc);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = pend[i] && (drop[i] == 0);
      req_beats[i*BW +: BW] = BW'(bts[i]);
    end
  endtask

  task automatic model_edge();
    done_who = -1;
    if (!m_busy) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (req_valid[c]) begin
          m_busy  = 1;
          m_owner = c;
          m_rem   = bts[c] + 1;
          exp_q.push_back('{c, m_rem});
          break;
        end
      end
    end else if (req_valid[m_owner] && out_ready) begin
      m_rem--;
      if (m_rem == 0) begin
        m_busy   = 0;
        m_last   = m_owner;
        done_who = m_owner;
      end
    end
  endtask

  task automatic agents();
    for (int i = 0; i < N; i++) begin
      if (done_who == i) pend[i] = rearm[i];
      if (drop[i] > 0) drop[i]--;
      else if (rand_mode && m_busy && m_owner == i &&
               $urandom_range(15) == 0)
        drop[i] = $urandom_range(4, 1);
      if (rand_mode && !pend[i] && $urandom_range(3) == 0) begin
        pend[i] = 1;
        bts[i]  = $urandom_range(5);
      end
    end
    if (rand_mode) out_ready = ($urandom_range(3) != 0);
  endtask

  task automatic tick();
    apply();
    @(posedge clock);
    model_edge();
    #1;
    agents();
    apply();
  endtask

  task automatic drain();
    int n;
    bit any_pend;
    rand_mode = 0;
    out_ready = 1;
    for (int i = 0; i < N; i++) rearm[i] = 0;
    n = 0;
    do begin
      any_pend = 0;
      for (int i = 0; i < N; i++) any_pend |= pend[i];
      if (m_busy || any_pend) begin
        tick();
        n++;
      end
    end while ((m_busy || any_pend) && n < 500);
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: model busy=%0d, required idle within 500 cycles",
               m_busy);
    end
    tick();
    tick();
  endtask

  task automatic reset_mid_burst();
    #1;
    reset_n = 0;
    #1;
    check("async_gnt", gnt, 0);
    check("async_busy", busy, 0);
    check("async_out_valid", out_valid, 0);
    m_busy  = 0;
    m_owner = 0;
    m_last  = N - 1;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      pend[i] = 0;
      drop[i] = 0;
    end
    apply();
    @(negedge clock);
    #1;
    reset_n = 1;
  endtask

  // monitor
  bit     mon_active = 0;
  burst_t cur;
  int     seen = 0;
  int     bcycles = 0;
  int     last_bcycles = 0;
  int     waitc[N];
  logic [N-1:0] vprev = '0;

  always @(negedge clock) begin
    cyc++;
    if (!reset_n) begin
      mon_active = 0;
      for (int i = 0; i < N; i++) waitc[i] = 0;
    end else begin
      check("gnt_onehot0", int'($onehot0(gnt)), 1);
      check("gnt_iff_busy", int'(gnt != '0), int'(busy));
      if (busy && !mon_active) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL grant_unexpected: sel %0d granted, expected no grant (cycle %0d)",
                   out_sel, cyc);
          cur = '{-1, 0};
        end else begin
          cur = exp_q.pop_front();
        end
        mon_active = 1;
        seen = 0;
        bcycles = 0;
        glog.push_back(int'(out_sel));
        gcyc.push_back(cyc);
        for (int i = 0; i < N; i++) begin
          if (i == int'(out_sel)) begin
            checks++;
            if (waitc[i] > N - 1) begin
              errors++;
              $display("FAIL wait_bound: req %0d waited %0d bursts, limit %0d",
                       i, waitc[i], N - 1);
            end
            waitc[i] = 0;
          end else if (vprev[i]) begin
            waitc[i]++;
          end
        end
      end
      if (mon_active) begin
        if (busy) begin
          bcycles++;
          check("sel_held", out_sel, cur.who);
          check("gnt_onehot_sel", gnt, 1 << cur.who);
          check("out_valid", out_valid, req_valid[cur.who]);
          check("out_last", out_last, int'(seen == cur.len - 1));
          if (out_valid && out_ready) seen++;
        end else begin
          check("burst_beats", seen, cur.len);
          last_bcycles = bcycles;
          mon_active = 0;
        end
      end else if (!busy) begin
        check("idle_sel", out_sel, 0);
        check("idle_last", out_last, 0);
        check("idle_valid", out_valid, 0);
      end
    end
    vprev = req_valid;
  end

  int exp1[6];

  initial begin
    for (int i = 0; i < N; i++) begin
      pend[i] = 0; rearm[i] = 0; bts[i] = 0; drop[i] = 0; waitc[i] = 0;
    end
    out_ready = 1;
    apply();

    // reset state
    repeat (2) @(negedge clock);
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sel", out_sel, 0);
    check("rst_out_last", out_last, 0);
    #1;
    reset_n = 1;
    tick();
    check("post_rst_gnt", gnt, 0);
    check("post_rst_busy", busy, 0);

    // three requesters, single beats, always re-requesting
    glog.delete(); gcyc.delete();
    for (int i = 0; i < 3; i++) begin
      pend[i] = 1; rearm[i] = 1; bts[i] = 0;
    end
    repeat (12) tick();
    drain();
    exp1 = '{0, 1, 2, 0, 1, 2};
    check("t1_grant_count_ok", int'(glog.size() >= 6), 1);
    for (int k = 0; k < 6; k++) begin
      check("t1_order", (k < glog.size()) ? glog[k] : -1, exp1[k]);
      if (k < 5)
        check("t1_spacing",
              (k + 1 < gcyc.size()) ? gcyc[k+1] - gcyc[k] : -1, 2);
    end

    // requester 1 alone, 4 beats, ready toggling
    pend[1] = 1; bts[1] = 3;
    begin
      bit rdy;
      rdy = 1;
      repeat (10) begin
        out_ready = rdy;
        tick();
        rdy = !rdy;
      end
    end
    drain();
    check("t2_gnt_cycles", last_bcycles, 8);

    // requester 0 arrives mid-burst of requester 2
    glog.delete(); gcyc.delete();
    pend[2] = 1; bts[2] = 1;
    tick();
    pend[0] = 1; bts[0] = 0;
    drain();
    check("t3_first", (glog.size() > 0) ? glog[0] : -1, 2);
    check("t3_second", (glog.size() > 1) ? glog[1] : -1, 0);
    check("t3_gap", (gcyc.size() > 1) ? gcyc[1] - gcyc[0] : -1, 3);

    // granted requester drops valid for 5 cycles
    pend[1] = 1; bts[1] = 3;
    tick();
    tick();
    drop[1] = 5;
    drain();
    check("t4_gnt_cycles", last_bcycles, 9);

    // reset during a 16-beat burst after requester 0 last won
    pend[0] = 1; bts[0] = 0;
    drain();
    pend[0] = 1; bts[0] = 15;
    repeat (5) tick();
    reset_mid_burst();
    glog.delete(); gcyc.delete();
    pend[0] = 1; bts[0] = 0;
    pend[1] = 1; bts[1] = 0;
    drain();
    check("t5_first_after_reset", (glog.size() > 0) ? glog[0] : -1, 0);

    // random traffic
    rand_mode = 1;
    repeat (10000) tick();
    drain();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/req_grant_arbiter.md
# req_grant_arbiter

Round-robin arbiter and burst sequencer that shares one downstream resource among `N_REQ` requesters. It issues a registered one-hot grant, keeps the grant locked for a whole multi-beat burst, and steers the winner's valid to the shared output. It sits directly in front of the shared port whose grant-exclusivity is checked by the generated `_assert` companion monitors. Its grant vector is guaranteed at-most-one-hot in every cycle out of reset.

## Interface
- `N_REQ`, 3, number of requesters (2..8)
- `BEAT_W`, 4, width of burst-length field; burst length = `req_beats`+1 (1..2^BEAT_W beats)
- `clock`  in  1  sole clock; all state updates on posedge
- `reset_n`  in  1  asynchronous, active-low reset; deassertion synchronised externally
- `req_valid`  in  N_REQ  per-requester beat valid; held high from request until burst end
- `req_beats`  in  N_REQ*BEAT_W  per-requester burst length minus one; sampled only at grant
- `out_ready`  in  1  shared resource accepts a beat this cycle
- `gnt`  out  N_REQ  registered one-hot grant (all-zero when idle)
- `out_valid`  out  1  `req_valid[sel] & (state==GRANT)`
- `out_sel`  out  clog2(N_REQ)  index of granted requester; 0 when idle
- `out_last`  out  1  current beat is final beat of burst
- `busy`  out  1  state==GRANT

## Operation
- States: IDLE, GRANT.
- IDLE: if any `req_valid`, select winner by round-robin starting at `(last_win+1) mod N_REQ`, wrapping. Next edge: `gnt`=onehot(winner), `out_sel`=winner, `beat_cnt`=`req_beats[winner]`, state->GRANT. No request: stay IDLE, outputs zero.
- GRANT: beat accepted when `out_valid & out_ready`. On accept with `beat_cnt`!=0: decrement. On accept with `beat_cnt`==0 (`out_last`): `last_win`<=`out_sel`, `gnt`<=0, state->IDLE.
- `out_last` = (state==GRANT) & (`beat_cnt`==0).
- Granted requester dropping `req_valid` mid-burst: grant held, `out_valid` low, `beat_cnt` frozen; no timeout, no preemption.
- Requests from non-granted requesters while GRANT: ignored until IDLE; no starvation, since each requester waits at most N_REQ-1 bursts.
- `req_beats` changes after grant: ignored.
- Width rule: `beat_cnt` is BEAT_W bits unsigned; it never underflows because decrement is only on non-last accept.

## Timing
- Reset (async assert): state=IDLE, `gnt`=0, `out_sel`=0, `beat_cnt`=0, `last_win`=N_REQ-1, so requester 0 wins first. All outputs 0 during and immediately after reset.
- Request-to-grant latency: 1 cycle (request sampled in IDLE at edge t, `gnt` valid after edge t).
- First beat can be accepted in the first GRANT cycle.
- One mandatory IDLE bubble cycle between bursts; peak throughput is L/(L+1) for bursts of length L.
- Single-beat burst (`req_beats`=0): `out_last`=1 in the first GRANT cycle.
- Reset asserted mid-burst: immediate return to the reset values; the burst is abandoned with no completion indication.
- Invariant: `$onehot0(gnt)` on every cycle; `gnt`!=0 iff busy.

## Structure
- Shared package `req_grant_arbiter_pkg`: state enum (IDLE, GRANT), `SEL_W = $clog2(N_REQ)` helper function, defaults for `N_REQ`/`BEAT_W`.
- One sub-module, `rr_pick`: combinational round-robin priority pick. Inputs: request vector and `last_win`. Outputs: winner index and any-request flag. Implemented by rotate, priority-encode, un-rotate.
- Companion `req_grant_arbiter_assert` monitor, in the existing assertion-module style: fatal on non-onehot0 `gnt`, or `out_valid` while idle, outside reset.

## Test plan
- Reset then `req_valid`=3'b111, all `req_beats`=0, `out_ready`=1 -> grants 0,1,2,0… on alternate cycles, with an IDLE bubble between each.
- Requester 1 alone, `req_beats[1]`=3, `out_ready` toggling 1,0,1,0… -> exactly 4 accepts; `out_last` on the 4th accept; `gnt`=3'b010 for 8 cycles, then 0.
- Requester 2 granted with 2-beat burst; requester 0 raises valid mid-burst -> 0 granted only after 2's last beat plus one IDLE cycle.
- Granted requester drops `req_valid` for 5 cycles mid-burst -> `gnt` held, `out_valid`=0, `beat_cnt` unchanged; burst completes after valid returns.
- `reset_n` pulsed low during 16-beat burst (`req_beats`=15) -> `gnt`=0 and busy=0 asynchronously; after release requester 0 wins first.
- Random requests for 10k cycles with `N_REQ`=5 -> `gnt` always onehot0, beat counts match `req_beats`+1, and per-requester wait never exceeds 4 bursts.
